// File: rtl/minsoc_dcm_rst_ctrl.sv
// minsoc_dcm_rst_ctrl
//   Drives the clock manager (DLL/DCM) reset and watches its LOCKED output.
//   System reset is released only after lock has been stable for LOCK_STABLE
//   cycles. If lock is lost, system reset is asserted again and the clock
//   manager is reset again. Runs on the undivided board clock (DCM CLKIN).
//
// Ports
//   clk_i         board clock (DCM CLKIN domain)
//   rst_i         synchronous active-high reset
//   dcm_locked_i  DCM LOCKED, asynchronous, synchronised here with 2 flops
//   dcm_rst_o     DCM RST, registered
//   sys_rst_o     system reset, active-high, registered
//   locked_o      high only while in RUN
//   lock_lost_o   sticky flag: lock dropped while in RUN; cleared by rst_i
//   retry_cnt_o   count of lock-timeout retries, saturates at 8'hFF
//   dcm_status_i  DCM STATUS bus, present only with DCM_CLKIN_STOP_EN
//
// Build option
//   DCM_CLKIN_STOP_EN : when defined, STATUS[1] (CLKIN stopped) is
//                       synchronised and treated as a loss of lock.
//                       Leave undefined for DLL/CLKDLL targets.
//
// sys_rst_o is asynchronous to the divided clock; consumers resynchronise it.
// A LOCK_STABLE of 32 or more covers the slowest divided clock (CLKDV /16).
//
// state     | meaning
// ----------+---------------------------------------------------------------
// DCM_RST   | dcm_rst_o high for DCM_RST_CYCLES cycles
// WAIT_LOCK | DCM out of reset; wait up to LOCK_TIMEOUT cycles for lock
// STABLE    | lock seen; require LOCK_STABLE consecutive lock cycles
// RUN       | system reset released; any lock drop restarts the DCM

module minsoc_dcm_rst_ctrl #(
  parameter int unsigned DCM_RST_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT   = 65535,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dcm_locked_i,
`ifdef DCM_CLKIN_STOP_EN
  input  logic [7:0] dcm_status_i,
`endif
  output logic       dcm_rst_o,
  output logic       sys_rst_o,
  output logic       locked_o,
  output logic       lock_lost_o,
  output logic [7:0] retry_cnt_o
);

  typedef enum logic [1:0] {
    S_DCM_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(DCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lk_meta_q, lk_meta_d;
  logic             lk_sync_q, lk_sync_d;
  logic             dcm_rst_q, dcm_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             locked_q, locked_d;
  logic             lock_lost_q, lock_lost_d;
  logic [7:0]       retry_cnt_q, retry_cnt_d;
  logic             lk_eff;

`ifdef DCM_CLKIN_STOP_EN
  logic             stop_meta_q, stop_meta_d;
  logic             stop_sync_q, stop_sync_d;
  logic             status_unused;

  // Only STATUS[1] (CLKIN stopped) matters here.
  assign status_unused = ^{dcm_status_i[7:2], dcm_status_i[0]};
  assign lk_eff        = lk_sync_q & ~stop_sync_q;
`else
  assign lk_eff        = lk_sync_q;
`endif

  always_comb begin
    lk_meta_d   = dcm_locked_i;
    lk_sync_d   = lk_meta_q;
`ifdef DCM_CLKIN_STOP_EN
    stop_meta_d = dcm_status_i[1];
    stop_sync_d = stop_meta_q;
`endif
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = lock_lost_q;
    retry_cnt_d = retry_cnt_q;

    case (state_q)
      S_DCM_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        // Lock wins over a timeout landing on the same cycle.
        if (lk_eff) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_DCM_RST;
          cnt_d   = '0;
          if (retry_cnt_q != 8'hFF) retry_cnt_d = retry_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STABLE: begin
        // A glitch sends us back with the full timeout available again.
        if (!lk_eff) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lk_eff) begin
          state_d     = S_DCM_RST;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end
      end
      default: begin
        state_d = S_DCM_RST;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they switch on the same
    // edge as the state register.
    dcm_rst_d = (state_d == S_DCM_RST);
    sys_rst_d = (state_d != S_RUN);
    locked_d  = (state_d == S_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_DCM_RST;
      cnt_q       <= '0;
      lk_meta_q   <= 1'b0;
      lk_sync_q   <= 1'b0;
`ifdef DCM_CLKIN_STOP_EN
      stop_meta_q <= 1'b0;
      stop_sync_q <= 1'b0;
`endif
      dcm_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      retry_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lk_meta_q   <= lk_meta_d;
      lk_sync_q   <= lk_sync_d;
`ifdef DCM_CLKIN_STOP_EN
      stop_meta_q <= stop_meta_d;
      stop_sync_q <= stop_sync_d;
`endif
      dcm_rst_q   <= dcm_rst_d;
      sys_rst_q   <= sys_rst_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign dcm_rst_o   = dcm_rst_q;
  assign sys_rst_o   = sys_rst_q;
  assign locked_o    = locked_q;
  assign lock_lost_o = lock_lost_q;
  assign retry_cnt_o = retry_cnt_q;

endmodule

// File: tb/tb_minsoc_dcm_rst_ctrl.sv
// Directed bench for minsoc_dcm_rst_ctrl with DCM_RST_CYCLES=4,
// LOCK_TIMEOUT=100, LOCK_STABLE=8. cyc counts rising edges; inputs are
// driven and outputs sampled 1 time unit after an edge.

module tb_minsoc_dcm_rst_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       dcm_locked_i;
  logic [7:0] dcm_status_i;
  logic       dcm_rst_o;
  logic       sys_rst_o;
  logic       locked_o;
  logic       lock_lost_o;
  logic [7:0] retry_cnt_o;

  int cyc    = 0;
  int nchk   = 0;
  int nerr   = 0;

  always #5 clk_i = ~clk_i;

  minsoc_dcm_rst_ctrl #(
    .DCM_RST_CYCLES(4),
    .LOCK_TIMEOUT  (100),
    .LOCK_STABLE   (8),
    .CNT_W         (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .dcm_locked_i(dcm_locked_i),
`ifdef DCM_CLKIN_STOP_EN
    .dcm_status_i(dcm_status_i),
`endif
    .dcm_rst_o   (dcm_rst_o),
    .sys_rst_o   (sys_rst_o),
    .locked_o    (locked_o),
    .lock_lost_o (lock_lost_o),
    .retry_cnt_o (retry_cnt_o)
  );

  task automatic tick_to(input int n);
    while (cyc < n) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic dr, input logic sr,
                         input logic lk, input logic ll, input logic [7:0] rc);
    chk({tag, ".dcm_rst"},   {7'd0, dcm_rst_o},   {7'd0, dr});
    chk({tag, ".sys_rst"},   {7'd0, sys_rst_o},   {7'd0, sr});
    chk({tag, ".locked"},    {7'd0, locked_o},    {7'd0, lk});
    chk({tag, ".lock_lost"}, {7'd0, lock_lost_o}, {7'd0, ll});
    chk({tag, ".retry"},     retry_cnt_o,         rc);
  endtask

  initial begin
    rst_i        = 1'b1;
    dcm_locked_i = 1'b0;
    dcm_status_i = 8'h00;

    // 1: normal bring-up
    tick_to(3);
    chk_all("reset", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    rst_i = 1'b0;
    tick_to(6);
    chk("bringup.dcm_rst_hi", {7'd0, dcm_rst_o}, 8'h01);
    tick_to(7);
    chk("bringup.dcm_rst_lo", {7'd0, dcm_rst_o}, 8'h00);
    tick_to(9);
    dcm_locked_i = 1'b1;               // first sampled at edge 10
    tick_to(19);
    chk("bringup.sys_rst_before", {7'd0, sys_rst_o}, 8'h01);
    tick_to(20);
    chk_all("bringup.run", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

    // 4: lock lost in RUN
    tick_to(22);
    dcm_locked_i = 1'b0;
    tick_to(24);
    chk("loss.sys_rst_still_lo", {7'd0, sys_rst_o}, 8'h00);
    tick_to(25);
    chk_all("loss.react", 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    tick_to(28);
    chk("loss.dcm_rst_pulse", {7'd0, dcm_rst_o}, 8'h01);
    tick_to(29);
    chk("loss.dcm_rst_end", {7'd0, dcm_rst_o}, 8'h00);
    dcm_locked_i = 1'b1;               // first sampled at edge 30
    tick_to(39);
    chk("relock.sys_rst_before", {7'd0, sys_rst_o}, 8'h01);
    tick_to(40);
    chk_all("relock.run", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

    // 5a: reset in RUN clears the sticky flag
    tick_to(41);
    rst_i        = 1'b1;
    dcm_locked_i = 1'b0;
    tick_to(42);
    chk_all("rst_in_run", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    rst_i = 1'b0;

    // 3: one-cycle glitch while in STABLE (WAIT_LOCK entered at edge 46)
    tick_to(46);
    dcm_locked_i = 1'b1;               // sampled 47, STABLE from 49
    tick_to(52);
    dcm_locked_i = 1'b0;               // sampled 53 only
    tick_to(53);
    dcm_locked_i = 1'b1;               // lock back, first sampled at 54
    tick_to(57);
    chk("glitch.no_release", {7'd0, sys_rst_o}, 8'h01);
    tick_to(63);
    chk("glitch.sys_rst_before", {7'd0, sys_rst_o}, 8'h01);
    tick_to(64);
    chk_all("glitch.run", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

    // 2: never locks (WAIT_LOCK entered at edge 69, retry every 104)
    rst_i        = 1'b1;
    dcm_locked_i = 1'b0;
    tick_to(65);
    rst_i = 1'b0;
    tick_to(168);
    chk("nolock.wait_dcm_rst", {7'd0, dcm_rst_o}, 8'h00);
    chk("nolock.retry0", retry_cnt_o, 8'h00);
    tick_to(169);
    chk("nolock.retry1_dcm_rst", {7'd0, dcm_rst_o}, 8'h01);
    chk("nolock.retry1", retry_cnt_o, 8'h01);
    tick_to(172);
    chk("nolock.pulse_hi", {7'd0, dcm_rst_o}, 8'h01);
    tick_to(173);
    chk("nolock.pulse_lo", {7'd0, dcm_rst_o}, 8'h00);
    tick_to(272);
    chk("nolock.retry1_hold", retry_cnt_o, 8'h01);
    tick_to(273);
    chk("nolock.retry2", retry_cnt_o, 8'h02);
    chk("nolock.retry2_dcm_rst", {7'd0, dcm_rst_o}, 8'h01);
    tick_to(377);
    chk("nolock.retry3", retry_cnt_o, 8'h03);
    tick_to(26481);
    chk("nolock.retry254", retry_cnt_o, 8'hFE);
    tick_to(26585);
    chk("nolock.retry255", retry_cnt_o, 8'hFF);
    tick_to(31300);
    chk("nolock.saturated", retry_cnt_o, 8'hFF);
    chk("nolock.in_wait", {7'd0, dcm_rst_o}, 8'h00);
    chk("nolock.sys_rst", {7'd0, sys_rst_o}, 8'h01);

    // 5b: reset in WAIT_LOCK clears the retry count
    rst_i = 1'b1;
    tick_to(31301);
    chk_all("rst_in_wait", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    rst_i = 1'b0;

`ifdef DCM_CLKIN_STOP_EN
    // 6: CLKIN-stopped status while lock stays high (WAIT_LOCK at 31305)
    tick_to(31305);
    dcm_locked_i = 1'b1;
    tick_to(31316);
    chk_all("stop.run", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick_to(31318);
    dcm_status_i = 8'h02;
    tick_to(31320);
    chk("stop.sys_rst_still_lo", {7'd0, sys_rst_o}, 8'h00);
    tick_to(31321);
    chk_all("stop.react", 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    dcm_status_i = 8'h00;
    tick_to(31333);
    chk("stop.sys_rst_before", {7'd0, sys_rst_o}, 8'h01);
    tick_to(31334);
    chk_all("stop.relock", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
`else
    tick_to(31310);
    chk("post_rst.wait_lock", {7'd0, dcm_rst_o}, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
